// File: rtl/boxcar_avg_mc_pkg.sv
// boxcar_pkg: shared constants and helpers for the multi-channel boxcar averager.
//   LOG2_NMAX_DEF : default log2 of the maximum averaging window
//   KW            : width of the window-exponent port
//   acc_width()   : width of a per-channel running sum
//   clamp_k()     : folds any 4-bit exponent request into the legal range 1..log2_nmax
package boxcar_pkg;

    localparam int LOG2_NMAX_DEF = 10;
    localparam int KW            = 4;

    // A sum of 2^log2_nmax samples of dw bits needs log2_nmax extra bits of headroom.
    function automatic int acc_width(input int dw, input int log2_nmax);
        return dw + log2_nmax;
    endfunction

    function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] k, input int log2_nmax);
        logic [KW-1:0] k_max;
        k_max = KW'(log2_nmax);
        if (k < 4'd1) begin
            return 4'd1;
        end else if (k > k_max) begin
            return k_max;
        end else begin
            return k;
        end
    endfunction

endpackage

// File: rtl/boxcar_avg_mc_if.sv
// boxcar_avg_mc_if: channel-tagged sample stream into the averager and the
// channel-tagged result stream out of it.
//   in_valid / in_channel / signal_in          : sample strobe, tag and signed sample
//   out_valid / out_channel / signal_out / settled : result pulse, tag, signed average,
//                                                    full-window qualifier
// master drives samples and observes results; slave is the averager side.
interface boxcar_avg_mc_if #(
    parameter int DW = 28,
    parameter int CW = 2
) ();

    logic                 in_valid;
    logic [CW-1:0]        in_channel;
    logic signed [DW-1:0] signal_in;
    logic                 out_valid;
    logic [CW-1:0]        out_channel;
    logic signed [DW-1:0] signal_out;
    logic                 settled;

    modport master (
        output in_valid, in_channel, signal_in,
        input  out_valid, out_channel, signal_out, settled
    );

    modport slave (
        input  in_valid, in_channel, signal_in,
        output out_valid, out_channel, signal_out, settled
    );

endinterface

// File: rtl/boxcar_avg_mc_ram.sv
// boxcar_ram: simple dual-port delay-line memory holding every channel's history.
//   clock_in : write and read clock
//   we/waddr/wdata : write port, address {channel, pointer}
//   re/raddr/rdata : read port, one-cycle registered read, address {channel, pointer}
// Reads and writes never target the same word in one cycle, so no collision
// behaviour is defined.
module boxcar_ram #(
    parameter int DW    = 28,
    parameter int AW    = 12,
    parameter int DEPTH = 4096
) (
    input  logic          clock_in,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] rdata_r;

    // write port
    always_ff @(posedge clock_in) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // registered read port
    always_ff @(posedge clock_in) begin
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/boxcar_avg_mc.sv
// boxcar_avg_mc: multi-channel moving-average filter over the last 2^k samples
// of each channel, sharing one pipeline and one history RAM.
//   clock_in : rising-edge clock
//   reset_n  : synchronous active-low reset
//   enable   : gates sample acceptance only; in-flight samples always complete
//   log2_n   : window exponent k, clamped to 1..LOG2_NMAX; a change clears all channels
//   bus      : slave side of the sample/result stream (boxcar_avg_mc_if)
// Pipeline: acceptance edge loads S1 (sample, tag, acc/fill snapshot, RAM read);
// the next edge commits the new sum (S2) and the edge after drives the outputs.
module boxcar_avg_mc
    import boxcar_pkg::*;
#(
    parameter int DW        = 28,
    parameter int LOG2_NMAX = LOG2_NMAX_DEF,
    parameter int CH        = 4,
    parameter int CW        = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clock_in,
    input  logic          reset_n,
    input  logic          enable,
    input  logic [KW-1:0] log2_n,
    boxcar_avg_mc_if.slave bus
);

    localparam int AW  = acc_width(DW, LOG2_NMAX);
    localparam int FW  = LOG2_NMAX + 1;
    localparam int CHW = CW + 1;
    localparam int RAW = CW + LOG2_NMAX;

    logic signed [AW-1:0]   acc_r  [CH];
    logic [FW-1:0]          fill_r [CH];
    logic [LOG2_NMAX-1:0]   wptr_r [CH];
    logic [KW-1:0]          k_r;

    logic                   s1_valid_r;
    logic [CW-1:0]          s1_ch_r;
    logic signed [DW-1:0]   s1_x_r;
    logic [FW-1:0]          s1_fill_r;
    logic signed [AW-1:0]   s1_acc_r;
    logic [LOG2_NMAX-1:0]   s1_ptr_r;

    logic                   s2_valid_r;
    logic [CW-1:0]          s2_ch_r;
    logic signed [DW-1:0]   s2_avg_r;
    logic                   s2_settled_r;

    logic                   out_valid_r;
    logic [CW-1:0]          out_channel_r;
    logic signed [DW-1:0]   signal_out_r;
    logic                   settled_r;

    logic [KW-1:0]          k_new_s;
    logic                   clear_s;
    logic [FW-1:0]          win_s;
    logic                   accept_s;
    logic                   fwd_s;
    logic [LOG2_NMAX-1:0]   rd_ptr_s;
    logic signed [DW-1:0]   ram_q_s;
    logic signed [AW-1:0]   x_ext_s;
    logic signed [AW-1:0]   old_s;
    logic signed [AW-1:0]   acc_new_s;
    logic [FW-1:0]          fill_new_s;
    logic signed [AW-1:0]   acc_rd_s;
    logic [FW-1:0]          fill_rd_s;
    logic signed [DW-1:0]   avg_s;
    logic                   settled_s;

    // acceptance, window clear detection and the S2 sum update
    always_comb begin
        k_new_s  = clamp_k(log2_n, LOG2_NMAX);
        clear_s  = (k_new_s != k_r);
        win_s    = FW'(1'b1) << k_r;
        accept_s = bus.in_valid & enable & ~clear_s &
                   ({1'b0, bus.in_channel} < CHW'(CH));
        // Oldest sample still inside the window; k>=1 keeps it off the S2 write slot.
        rd_ptr_s = wptr_r[bus.in_channel] - win_s[LOG2_NMAX-1:0];

        // Until the window has filled, the history behaves as zeros.
        x_ext_s  = {{LOG2_NMAX{s1_x_r[DW-1]}}, s1_x_r};
        if (s1_fill_r < win_s) begin
            old_s      = {AW{1'b0}};
            fill_new_s = s1_fill_r + FW'(1'b1);
        end else begin
            old_s      = {{LOG2_NMAX{ram_q_s[DW-1]}}, ram_q_s};
            fill_new_s = s1_fill_r;
        end
        acc_new_s = s1_acc_r + x_ext_s - old_s;
        avg_s     = DW'(acc_new_s >>> k_r);
        settled_s = (fill_new_s == win_s) & ~clear_s;

        // A same-channel sample right behind S2 must see the sum S2 is committing now.
        fwd_s = s1_valid_r & (s1_ch_r == bus.in_channel);
        if (fwd_s) begin
            acc_rd_s  = acc_new_s;
            fill_rd_s = fill_new_s;
        end else begin
            acc_rd_s  = acc_r[bus.in_channel];
            fill_rd_s = fill_r[bus.in_channel];
        end
    end

    // per-channel running sums and fill counts; a window change zeroes them all
    always_ff @(posedge clock_in) begin
        if (!reset_n || clear_s) begin
            for (int i = 0; i < CH; i++) begin
                acc_r[i]  <= {AW{1'b0}};
                fill_r[i] <= {FW{1'b0}};
            end
        end else if (s1_valid_r) begin
            acc_r[s1_ch_r]  <= acc_new_s;
            fill_r[s1_ch_r] <= fill_new_s;
        end
    end

    // per-channel write pointers, kept across window changes
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) begin
                wptr_r[i] <= {LOG2_NMAX{1'b0}};
            end
        end else if (accept_s) begin
            wptr_r[bus.in_channel] <= wptr_r[bus.in_channel] + LOG2_NMAX'(1'b1);
        end
    end

    // window register, pipeline stages and output registers
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            k_r           <= {KW{1'b0}};
            s1_valid_r    <= 1'b0;
            s1_ch_r       <= {CW{1'b0}};
            s1_x_r        <= {DW{1'b0}};
            s1_fill_r     <= {FW{1'b0}};
            s1_acc_r      <= {AW{1'b0}};
            s1_ptr_r      <= {LOG2_NMAX{1'b0}};
            s2_valid_r    <= 1'b0;
            s2_ch_r       <= {CW{1'b0}};
            s2_avg_r      <= {DW{1'b0}};
            s2_settled_r  <= 1'b0;
            out_valid_r   <= 1'b0;
            out_channel_r <= {CW{1'b0}};
            signal_out_r  <= {DW{1'b0}};
            settled_r     <= 1'b0;
        end else begin
            k_r        <= k_new_s;
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_ch_r   <= bus.in_channel;
                s1_x_r    <= bus.signal_in;
                s1_fill_r <= fill_rd_s;
                s1_acc_r  <= acc_rd_s;
                s1_ptr_r  <= wptr_r[bus.in_channel];
            end
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_ch_r      <= s1_ch_r;
                s2_avg_r     <= avg_s;
                s2_settled_r <= settled_s;
            end
            out_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                out_channel_r <= s2_ch_r;
                signal_out_r  <= s2_avg_r;
                settled_r     <= s2_settled_r;
            end
        end
    end

    boxcar_ram #(
        .DW   (DW),
        .AW   (RAW),
        .DEPTH(CH << LOG2_NMAX)
    ) u_ram (
        .clock_in(clock_in),
        .we      (s1_valid_r),
        .waddr   ({s1_ch_r, s1_ptr_r}),
        .wdata   (s1_x_r),
        .re      (accept_s),
        .raddr   ({bus.in_channel, rd_ptr_s}),
        .rdata   (ram_q_s)
    );

    assign bus.out_valid   = out_valid_r;
    assign bus.out_channel = out_channel_r;
    assign bus.signal_out  = signal_out_r;
    assign bus.settled     = settled_r;

endmodule

// File: tb/tb_boxcar_avg_mc.sv
// Self-checking bench for boxcar_avg_mc: a history-summing reference model
// queues expected results as samples are driven; a monitor compares DUT output.
module tb_boxcar_avg_mc;

    localparam int DW = 28;
    localparam int L2 = 10;
    localparam int CH = 4;
    localparam int CW = 2;

    typedef struct {
        int                   ch;
        logic signed [DW-1:0] val;
        bit                   stl;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] log2_n;

    always #5 clk = ~clk;

    boxcar_avg_mc_if #(.DW(DW), .CW(CW)) bus ();

    boxcar_avg_mc #(.DW(DW), .LOG2_NMAX(L2), .CH(CH), .CW(CW)) dut (
        .clock_in(clk),
        .reset_n (rst_n),
        .enable  (enable),
        .log2_n  (log2_n),
        .bus     (bus)
    );

    res_t exp_q[$];
    res_t got_q[$];
    res_t mon_got;
    res_t mon_exp;

    logic signed [DW-1:0] hbuf [CH][1024];
    int  widx [CH];
    int  cnt  [CH];
    int  mk;
    bit  prev_acc;
    int  n_tests = 0;
    int  n_fail  = 0;

    function automatic int tb_clamp(input int k);
        if (k < 1) return 1;
        if (k > L2) return L2;
        return k;
    endfunction

    // Drive one cycle of input and advance the reference model accordingly.
    task automatic drive(input bit v, input int ch, input int x, input bit en, input int k);
        int   kc;
        bit   acc;
        int   take;
        int   win;
        longint sum;
        res_t r;
        @(negedge clk);
        bus.in_valid   = v;
        bus.in_channel = CW'(ch);
        bus.signal_in  = DW'(x);
        enable         = en;
        log2_n         = 4'(k);
        kc = tb_clamp(k);
        if (kc != mk) begin
            mk = kc;
            for (int c = 0; c < CH; c++) cnt[c] = 0;
            if (prev_acc && exp_q.size() > 0) begin
                r = exp_q.pop_back();
                r.stl = 1'b0;
                exp_q.push_back(r);
            end
            acc = 1'b0;
        end else begin
            acc = v && en && (ch < CH);
        end
        if (acc) begin
            hbuf[ch][widx[ch]] = DW'(x);
            widx[ch] = (widx[ch] + 1) % 1024;
            cnt[ch]++;
            win  = 1 << mk;
            take = (cnt[ch] < win) ? cnt[ch] : win;
            sum  = 0;
            for (int j = 0; j < take; j++) begin
                sum = sum + hbuf[ch][(widx[ch] - 1 - j + 1024) % 1024];
            end
            r.ch  = ch;
            r.val = DW'(sum >>> mk);
            r.stl = (cnt[ch] >= win);
            exp_q.push_back(r);
        end
        prev_acc = acc;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        enable       = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        // The first edge out of reset reloads the window register: a clear.
        mk       = tb_clamp(int'(log2_n));
        prev_acc = 1'b0;
        for (int c = 0; c < CH; c++) cnt[c] = 0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            drive(0, 0, 0, 1, mk);
            t++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d results pending, required 0", name, exp_q.size());
        end
        repeat (3) drive(0, 0, 0, 1, mk);
    endtask

    function automatic int rnd_full();
        return int'($urandom_range(32'd268435455, 32'd0)) - 134217728;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            mon_got.ch  = int'(bus.out_channel);
            mon_got.val = bus.signal_out;
            mon_got.stl = bus.settled;
            got_q.push_back(mon_got);
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got ch=%0d val=%0d, required no output",
                         mon_got.ch, mon_got.val);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got.ch !== mon_exp.ch || mon_got.val !== mon_exp.val ||
                    mon_got.stl !== mon_exp.stl) begin
                    n_fail++;
                    $display("FAIL scoreboard: got ch=%0d val=%0d settled=%0b, required ch=%0d val=%0d settled=%0b",
                             mon_got.ch, mon_got.val, mon_got.stl, mon_exp.ch, mon_exp.val, mon_exp.stl);
                end
            end
        end
    end

    task automatic test_reset();
        do_reset(2);
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b, required 0", bus.out_valid); end
        n_tests++;
        if (bus.signal_out !== 28'sd0) begin n_fail++; $display("FAIL reset_signal_out: got %0d, required 0", bus.signal_out); end
        n_tests++;
        if (bus.out_channel !== 2'd0) begin n_fail++; $display("FAIL reset_out_channel: got %0d, required 0", bus.out_channel); end
        n_tests++;
        if (bus.settled !== 1'b0) begin n_fail++; $display("FAIL reset_settled: got %0b, required 0", bus.settled); end
    endtask

    task automatic test_single();
        int want_v [5] = '{1, 3, 6, 10, 14};
        bit want_s [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        got_q.delete();
        drive(0, 0, 0, 1, 2);
        for (int i = 0; i < 5; i++) drive(1, 0, 4 * (i + 1), 1, 2);
        drain("single");
        n_tests++;
        if (got_q.size() != 5) begin n_fail++; $display("FAIL single_count: got %0d, required 5", got_q.size()); end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i].val !== DW'(want_v[i]) || got_q[i].stl !== want_s[i]) begin
                n_fail++;
                $display("FAIL single_out%0d: got %0d/%0b, required %0d/%0b",
                         i, got_q[i].val, got_q[i].stl, want_v[i], want_s[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        int   n3;
        res_t last [CH];
        got_q.delete();
        drive(0, 0, 0, 1, 3);
        for (int r = 0; r < 16; r++) begin
            drive(1, 0, 100, 1, 3);
            drive(1, 1, -100, 1, 3);
            drive(1, 2, (r % 2 == 1) ? 8 : 0, 1, 3);
        end
        drain("rr");
        n3 = 0;
        for (int i = 0; i < got_q.size(); i++) begin
            last[got_q[i].ch] = got_q[i];
            if (got_q[i].ch == 3) n3++;
        end
        n_tests++;
        if (last[0].val !== 28'sd100 || last[0].stl !== 1'b1) begin n_fail++; $display("FAIL rr_ch0: got %0d/%0b, required 100/1", last[0].val, last[0].stl); end
        n_tests++;
        if (last[1].val !== -28'sd100 || last[1].stl !== 1'b1) begin n_fail++; $display("FAIL rr_ch1: got %0d/%0b, required -100/1", last[1].val, last[1].stl); end
        n_tests++;
        if (last[2].val !== 28'sd4 || last[2].stl !== 1'b1) begin n_fail++; $display("FAIL rr_ch2: got %0d/%0b, required 4/1", last[2].val, last[2].stl); end
        n_tests++;
        if (n3 != 0) begin n_fail++; $display("FAIL rr_ch3_idle: got %0d outputs, required 0", n3); end
        for (int i = 0; i < 80; i++) begin
            drive(1, int'($urandom_range(3, 0)), int'($urandom_range(2000, 0)) - 1000, 1, 3);
        end
        drain("rr_random");
    endtask

    task automatic test_back_to_back();
        got_q.delete();
        drive(0, 0, 0, 1, 1);
        drive(1, 3, -3, 1, 1);
        for (int i = 0; i < 40; i++) drive(1, 0, rnd_full(), 1, 1);
        for (int i = 0; i < 60; i++) drive(1, int'($urandom_range(3, 0)), rnd_full(), 1, 1);
        drain("b2b");
        n_tests++;
        if (got_q.size() < 1 || got_q[0].ch != 3 || got_q[0].val !== -28'sd2) begin
            n_fail++;
            $display("FAIL b2b_floor: got %0d, required ch3 -2", (got_q.size() > 0) ? int'(got_q[0].val) : 0);
        end
    endtask

    task automatic test_k_change();
        got_q.delete();
        drive(0, 0, 0, 1, 3);
        for (int i = 0; i < 40; i++) drive(1, i % 4, int'($urandom_range(500, 0)), 1, 3);
        drive(1, 0, 77, 1, 5);
        for (int j = 0; j < 136; j++) drive(1, j % 4, int'($urandom_range(500, 0)), 1, 5);
        drain("kchg");
        n_tests++;
        if (got_q.size() != 176) begin
            n_fail++;
            $display("FAIL kchg_count: got %0d, required 176", got_q.size());
        end else begin
            n_tests++;
            if (got_q[38].stl !== 1'b1 || got_q[39].stl !== 1'b0) begin
                n_fail++;
                $display("FAIL kchg_inflight: got %0b/%0b, required 1/0", got_q[38].stl, got_q[39].stl);
            end
            n_tests++;
            if (got_q[40 + 123].stl !== 1'b0 || got_q[40 + 127].stl !== 1'b1) begin
                n_fail++;
                $display("FAIL kchg_resettle: got %0b/%0b, required 0/1",
                         got_q[40 + 123].stl, got_q[40 + 127].stl);
            end
        end
    endtask

    task automatic test_enable();
        got_q.delete();
        drive(1, 0, 7, 1, 5);
        drive(1, 1, 9, 1, 5);
        for (int i = 0; i < 10; i++) drive(1, 2, 55, 0, 5);
        n_tests++;
        if (got_q.size() != 2) begin n_fail++; $display("FAIL enable_inflight: got %0d outputs, required 2", got_q.size()); end
        for (int i = 0; i < 12; i++) drive(1, i % 4, 3 * i, 1, 5);
        drain("enable");
    endtask

    task automatic test_reset_midstream();
        got_q.delete();
        drive(1, 0, 1000, 1, 5);
        drive(1, 1, 2000, 1, 5);
        do_reset(2);
        repeat (3) @(negedge clk);
        n_tests++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_out: got %0d outputs, required 0", got_q.size()); end
        drive(0, 0, 0, 1, 2);
        drive(1, 0, 40, 1, 2);
        drain("rst_mid");
        n_tests++;
        if (got_q.size() != 1 || got_q[0].val !== 28'sd10 || got_q[0].stl !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_fresh: got %0d outputs val %0d, required 1 output 10/0",
                     got_q.size(), (got_q.size() > 0) ? int'(got_q[0].val) : 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        enable         = 1'b1;
        log2_n         = 4'd2;
        bus.in_valid   = 1'b0;
        bus.in_channel = 2'd0;
        bus.signal_in  = 28'sd0;
        mk             = 0;
        prev_acc       = 1'b0;
        for (int c = 0; c < CH; c++) begin
            widx[c] = 0;
            cnt[c]  = 0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_k_change();
        test_enable();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
